// File: rtl/fetch_pkg.sv
// Shared constants for the LEGv8 fetch stage and IF/ID register.
// NOP_INSTR decodes to all-zero control, so flushed slots are harmless.
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int PC_INC = 4;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 21;
endpackage

// File: rtl/fetch_ifid_if.sv
// Fetch <-> imem / decode / hazard-unit signal bundle.
// master is the fetch side, slave is the surrounding pipeline.
interface fetch_ifid_if #(
  parameter int N = 64
);
  logic         stall_d;
  logic         pcsrc;
  logic [N-1:0] pc_branch;
  logic [N-1:0] imem_addr;
  logic [31:0]  imem_data;
  logic [31:0]  instr_d;
  logic [10:0]  op_d;
  logic [N-1:0] pc_d;
  logic         valid_d;
  logic [31:0]  fetch_count;

  modport master (
    input  stall_d, pcsrc, pc_branch, imem_data,
    output imem_addr, instr_d, op_d, pc_d,
    output valid_d, fetch_count
  );

  modport slave (
    output stall_d, pcsrc, pc_branch, imem_data,
    input  imem_addr, instr_d, op_d, pc_d,
    input  valid_d, fetch_count
  );
endinterface

// File: rtl/flopre.sv
// Generic W-bit register with synchronous reset and load enable.
module flopre #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)
      r_q <= RST_VAL;
    else if (i_en)
      r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/fetch_ifid.sv
// LEGv8 IF stage: PC, next-PC select, and the IF/ID register.
// Priority: reset > redirect (flush) > stall > advance.
module fetch_ifid
  import fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input logic       clk,
  input logic       reset,
  fetch_ifid_if.master bus
);
  localparam int IFID_W = 32 + N + 1;

  logic [N-1:0]      w_pc;
  logic [N-1:0]      w_pc_plus4;
  logic [N-1:0]      w_br;
  logic [N-1:0]      w_pc_next;
  logic [IFID_W-1:0] w_ifid_d;
  logic [IFID_W-1:0] w_ifid_q;
  logic [31:0]       w_cnt_q;
  logic [31:0]       w_instr;
  logic              w_pc_en;
  logic              w_cnt_en;

  assign w_pc_plus4 = w_pc + N'(PC_INC);
  assign w_br = bus.pc_branch & ~{{(N-2){1'b0}}, 2'b11};

  // A redirect flushes the slot; the word on imem_data is dropped.
  always_comb begin
    w_pc_next = w_pc_plus4;
    w_ifid_d  = {bus.imem_data, w_pc, 1'b1};
    unique case (1'b1)
      bus.pcsrc: begin
        w_pc_next = w_br;
        w_ifid_d  = {NOP_INSTR, {N{1'b0}}, 1'b0};
      end
      default: begin
        w_pc_next = w_pc_plus4;
        w_ifid_d  = {bus.imem_data, w_pc, 1'b1};
      end
    endcase
  end

  assign w_pc_en  = bus.pcsrc | ~bus.stall_d;
  assign w_cnt_en = ~bus.pcsrc & ~bus.stall_d;

  flopre #(
    .W      (N),
    .RST_VAL(RESET_PC)
  ) u_pc (
    .clk  (clk),
    .reset(reset),
    .i_en (w_pc_en),
    .i_d  (w_pc_next),
    .o_q  (w_pc)
  );

  flopre #(
    .W      (IFID_W),
    .RST_VAL('0)
  ) u_ifid (
    .clk  (clk),
    .reset(reset),
    .i_en (w_pc_en),
    .i_d  (w_ifid_d),
    .o_q  (w_ifid_q)
  );

  flopre #(
    .W      (32),
    .RST_VAL('0)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .i_en (w_cnt_en),
    .i_d  (w_cnt_q + 32'd1),
    .o_q  (w_cnt_q)
  );

  assign w_instr         = w_ifid_q[IFID_W-1 -: 32];
  assign bus.imem_addr   = w_pc;
  assign bus.instr_d     = w_instr;
  assign bus.op_d        = w_instr[OP_MSB:OP_LSB];
  assign bus.pc_d        = w_ifid_q[N:1];
  assign bus.valid_d     = w_ifid_q[0];
  assign bus.fetch_count = w_cnt_q;
endmodule

// File: tb/tb_fetch_ifid.sv
// Bench for fetch_ifid: reference model plus directed checks,
// second instance exercises PC wrap from RESET_PC = 2^64-4.
module tb_fetch_ifid;
  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic reset;
  int   n_tot  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fetch_ifid_if #(.N(64)) if1 ();
  fetch_ifid_if #(.N(64)) if2 ();

  fetch_ifid #(.N(64), .RESET_PC(64'h0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (if1)
  );

  fetch_ifid #(.N(64), .RESET_PC(TOP_PC)) dut_wrap (
    .clk  (clk),
    .reset(reset),
    .bus  (if2)
  );

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF840_0041;
      64'h4:   return 32'h8B02_0021;
      64'h8:   return 32'hF800_8003;
      default: return a[31:0] ^ 32'h1234_5678;
    endcase
  endfunction

  assign if1.imem_data = mem_f(if1.imem_addr);
  assign if2.imem_data = mem_f(if2.imem_addr);

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: the spec's per-cycle rules for dut.
  logic [63:0] m_pc, m_pcd;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid;
  logic        m_init = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_init  <= 1'b1;
      m_pc    <= 64'h0;
      m_instr <= 32'h0;
      m_pcd   <= 64'h0;
      m_valid <= 1'b0;
      m_cnt   <= 32'h0;
    end else if (m_init && if1.pcsrc) begin
      m_pc    <= {if1.pc_branch[63:2], 2'b00};
      m_instr <= 32'h0;
      m_pcd   <= 64'h0;
      m_valid <= 1'b0;
    end else if (m_init && !if1.stall_d) begin
      m_pc    <= m_pc + 64'd4;
      m_instr <= mem_f(m_pc);
      m_pcd   <= m_pc;
      m_valid <= 1'b1;
      m_cnt   <= m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_addr", if1.imem_addr, m_pc);
      chk("m_instr", {32'h0, if1.instr_d}, {32'h0, m_instr});
      chk("m_op", {53'h0, if1.op_d}, {53'h0, m_instr[31:21]});
      chk("m_pcd", if1.pc_d, m_pcd);
      chk("m_valid", {63'h0, if1.valid_d}, {63'h0, m_valid});
      chk("m_cnt", {32'h0, if1.fetch_count}, {32'h0, m_cnt});
    end
  end

  task automatic step(input logic rs, input logic st,
                      input logic ps, input logic [63:0] br);
    reset         = rs;
    if1.stall_d   = st;
    if1.pcsrc     = ps;
    if1.pc_branch = br;
    @(posedge clk);
    #1;
  endtask

  initial begin
    if2.stall_d   = 1'b0;
    if2.pcsrc     = 1'b0;
    if2.pc_branch = 64'h0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_addr", if1.imem_addr, 64'h0);
    chk("rst_valid", {63'h0, if1.valid_d}, 64'h0);
    chk("rst_instr", {32'h0, if1.instr_d}, 64'h0);
    chk("rst_cnt", {32'h0, if1.fetch_count}, 64'h0);
    chk("wrap_rst_addr", if2.imem_addr, TOP_PC);

    step(0, 0, 0, 0);
    chk("f1_addr", if1.imem_addr, 64'h4);
    chk("f1_pcd", if1.pc_d, 64'h0);
    chk("f1_op", {53'h0, if1.op_d}, 64'h7C2);
    chk("wrap_addr", if2.imem_addr, 64'h0);
    chk("wrap_pcd", if2.pc_d, TOP_PC);
    chk("wrap_valid", {63'h0, if2.valid_d}, 64'h1);
    step(0, 0, 0, 0);
    chk("f2_addr", if1.imem_addr, 64'h8);
    chk("f2_pcd", if1.pc_d, 64'h4);
    chk("f2_op", {53'h0, if1.op_d}, 64'h458);
    step(0, 0, 0, 0);
    chk("f3_addr", if1.imem_addr, 64'hC);
    chk("f3_pcd", if1.pc_d, 64'h8);
    chk("f3_op", {53'h0, if1.op_d}, 64'h7C0);
    chk("f3_cnt", {32'h0, if1.fetch_count}, 64'd3);

    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("st_addr", if1.imem_addr, 64'hC);
    chk("st_pcd", if1.pc_d, 64'h8);
    chk("st_cnt", {32'h0, if1.fetch_count}, 64'd3);
    step(0, 0, 0, 0);
    chk("rel_pcd", if1.pc_d, 64'hC);
    chk("rel_cnt", {32'h0, if1.fetch_count}, 64'd4);

    step(0, 1, 1, 64'h40);
    chk("br_addr", if1.imem_addr, 64'h40);
    chk("br_valid", {63'h0, if1.valid_d}, 64'h0);
    chk("br_instr", {32'h0, if1.instr_d}, 64'h0);
    chk("br_op", {53'h0, if1.op_d}, 64'h0);
    chk("br_cnt", {32'h0, if1.fetch_count}, 64'd4);
    step(0, 0, 0, 0);
    chk("br2_pcd", if1.pc_d, 64'h40);
    chk("br2_valid", {63'h0, if1.valid_d}, 64'h1);
    step(0, 0, 1, 64'h43);
    chk("br_align", if1.imem_addr, 64'h40);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    step(1, 1, 1, 64'h80);
    chk("mrst_addr", if1.imem_addr, 64'h0);
    chk("mrst_valid", {63'h0, if1.valid_d}, 64'h0);
    chk("mrst_pcd", if1.pc_d, 64'h0);
    chk("mrst_cnt", {32'h0, if1.fetch_count}, 64'h0);
    chk("wrap_mrst", if2.imem_addr, TOP_PC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
